// File: rtl/segled_rx.sv
// Serial 7-segment display frame receiver.
// Rebuilds SEGLED_* shift/latch traffic into parallel frames in the clk domain.
module segled_rx #(
  parameter int NBITS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seg_clk,
  input  logic             seg_do,
  input  logic             seg_pen,
  input  logic             seg_clr,
  output logic [NBITS-1:0] frame,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [6:0]       bit_cnt,
  output logic [15:0]      frame_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam logic [6:0] CNT_FULL = 7'(NBITS);
  localparam logic [6:0] CNT_MAX  = 7'(NBITS + 1);

  // clk and pen carry a third stage for edge detection;
  // do and clr are only ever used as levels.
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [2:0]       pen_sync_q, pen_sync_d;
  logic [1:0]       do_sync_q, do_sync_d;
  logic [1:0]       clr_sync_q, clr_sync_d;

  state_e           state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [NBITS-1:0] frame_q, frame_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [15:0]      fcnt_q, fcnt_d;

  logic             shift_ev;
  logic             pen_ev;
  logic             clr_act;

  assign shift_ev = clk_sync_q[1] & ~clk_sync_q[2];
  assign pen_ev   = pen_sync_q[1] & ~pen_sync_q[2];
  assign clr_act  = ~clr_sync_q[1];

  // Synchronizer chains: new sample enters bit 0.
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], seg_clk};
    pen_sync_d = {pen_sync_q[1:0], seg_pen};
    do_sync_d  = {do_sync_q[0], seg_do};
    clr_sync_d = {clr_sync_q[0], seg_clr};
  end

  // Next-state: clear beats everything; a shift in the latch cycle lands first.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    if (clr_act) begin
      shift_d = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      if (state_q == LATCH) begin
        state_d = IDLE;
      end
      if (shift_ev) begin
        shift_d = {shift_q[NBITS-2:0], do_sync_q[1]};
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 7'd1;
        state_d = SHIFT;
      end
      if (pen_ev) begin
        if (cnt_d == CNT_FULL) begin
          frame_d = shift_d;
          valid_d = 1'b1;
          fcnt_d  = fcnt_q + 16'd1;
        end else begin
          err_d = 1'b1;
        end
        shift_d = '0;
        cnt_d   = '0;
        state_d = LATCH;
      end
    end
  end

  // All state, including synchronizers, resets asynchronously to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= '0;
      pen_sync_q <= '0;
      do_sync_q  <= '0;
      clr_sync_q <= '0;
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      frame_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      pen_sync_q <= pen_sync_d;
      do_sync_q  <= do_sync_d;
      clr_sync_q <= clr_sync_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign bit_cnt     = cnt_q;
  assign frame_cnt   = fcnt_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_segled_rx.sv
// Randomized bench for segled_rx.
// Reference keeps shifted bits in a queue and decides frames by count.
module tb_segled_rx;

  localparam int NB = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          seg_clk = 1'b0;
  logic          seg_do = 1'b0;
  logic          seg_pen = 1'b0;
  logic          seg_clr = 1'b1;
  logic [NB-1:0] frame;
  logic          frame_valid;
  logic          frame_err;
  logic [6:0]    bit_cnt;
  logic [15:0]   frame_cnt;
  logic          busy;

  segled_rx #(.NBITS(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_clk     (seg_clk),
    .seg_do      (seg_do),
    .seg_pen     (seg_pen),
    .seg_clr     (seg_clr),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .bit_cnt     (bit_cnt),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  bit            m_bits[$];
  logic [NB-1:0] m_frame = '0;
  logic [15:0]   m_fcnt = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int exp_cnt();
    return (m_bits.size() > NB + 1) ? NB + 1 : m_bits.size();
  endfunction

  // Last NB bits in arrival order, first arrival most significant.
  function automatic logic [NB-1:0] m_pack();
    logic [NB-1:0] v = '0;
    foreach (m_bits[i]) v = v * 2 + NB'(m_bits[i]);
    return v;
  endfunction

  task automatic shift_bit(input bit b);
    seg_do = b;
    cyc(4);
    seg_clk = 1'b1;
    m_bits.push_back(b);
    cyc(4);
    chk("bit_cnt", 64'(bit_cnt), 64'(exp_cnt()));
    chk("busy", 64'(busy), 64'(1));
    seg_clk = 1'b0;
  endtask

  task automatic send_word(input logic [NB-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i % NB]);
  endtask

  // Pen pulse, optionally on the same cycle as one last seg_clk rise.
  task automatic latch(input bit with_bit, input bit b);
    bit ev;
    bit ee;
    if (with_bit) begin
      seg_do = b;
      cyc(4);
      seg_clk = 1'b1;
      m_bits.push_back(b);
    end
    seg_pen = 1'b1;
    ev = (m_bits.size() == NB);
    ee = !ev;
    if (ev) begin
      m_frame = m_pack();
      m_fcnt  = m_fcnt + 16'd1;
    end
    m_bits.delete();
    cyc(2);
    chk("pre_valid", 64'(frame_valid), 64'(0));
    chk("pre_err", 64'(frame_err), 64'(0));
    cyc(1);
    chk("valid", 64'(frame_valid), 64'(ev));
    chk("err", 64'(frame_err), 64'(ee));
    cyc(1);
    chk("post_valid", 64'(frame_valid), 64'(0));
    chk("post_err", 64'(frame_err), 64'(0));
    seg_pen = 1'b0;
    seg_clk = 1'b0;
    cyc(4);
    chk("frame", frame, m_frame);
    chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
    chk("cnt_after", 64'(bit_cnt), 64'(0));
    chk("busy_after", 64'(busy), 64'(0));
  endtask

  task automatic clear_pulse();
    seg_clr = 1'b0;
    cyc(4);
    chk("clr_cnt", 64'(bit_cnt), 64'(0));
    chk("clr_busy", 64'(busy), 64'(0));
    m_bits.delete();
    seg_clr = 1'b1;
    cyc(4);
  endtask

  logic [NB-1:0] rv;
  int            len;

  initial begin
    cyc(3);
    chk("rst_frame", frame, 64'(0));
    chk("rst_valid", 64'(frame_valid), 64'(0));
    chk("rst_err", 64'(frame_err), 64'(0));
    chk("rst_cnt", 64'(bit_cnt), 64'(0));
    chk("rst_fcnt", 64'(frame_cnt), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b1;
    cyc(4);

    rv = 64'hC0F9A4B099929282;
    send_word(rv, NB);
    latch(1'b0, 1'b0);

    rv = {$urandom, $urandom};
    send_word(rv, NB - 1);
    latch(1'b0, 1'b0);

    rv = {$urandom, $urandom};
    send_word(rv, NB + 1);
    chk("cnt65", 64'(bit_cnt), 64'(NB + 1));
    shift_bit(1'b1);
    chk("cnt_sat", 64'(bit_cnt), 64'(NB + 1));
    latch(1'b0, 1'b0);

    rv = {$urandom, $urandom};
    send_word(rv, 32);
    clear_pulse();
    rv = 64'hFFFFFFFF00000000;
    send_word(rv, NB);
    latch(1'b0, 1'b0);

    rv = {$urandom, $urandom};
    send_word(rv >> 1, NB - 1);
    latch(1'b1, rv[0]);

    rv = {$urandom, $urandom};
    send_word(rv, NB);
    seg_clr = 1'b0;
    seg_pen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("clrpen_valid", 64'(frame_valid), 64'(0));
      chk("clrpen_err", 64'(frame_err), 64'(0));
    end
    m_bits.delete();
    seg_clr = 1'b1;
    cyc(4);
    seg_pen = 1'b0;
    cyc(4);
    chk("clrpen_cnt", 64'(bit_cnt), 64'(0));
    chk("clrpen_frame", frame, m_frame);
    chk("clrpen_fcnt", 64'(frame_cnt), 64'(m_fcnt));

    for (int k = 0; k < 8; k++) begin
      rv  = {$urandom, $urandom};
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(NB - 3, NB + 3) : NB;
      if ($urandom_range(0, 1) == 1 && len > 0) begin
        send_word(rv >> 1, len - 1);
        latch(1'b1, rv[0]);
      end else begin
        send_word(rv, len);
        latch(1'b0, 1'b0);
      end
    end

    force dut.fcnt_q = 16'hFFFF;
    cyc(2);
    release dut.fcnt_q;
    m_fcnt = 16'hFFFF;
    cyc(1);
    chk("fcnt_preload", 64'(frame_cnt), 64'hFFFF);
    rv = {$urandom, $urandom};
    send_word(rv, NB);
    latch(1'b0, 1'b0);
    chk("fcnt_wrap", 64'(frame_cnt), 64'(0));

    send_word(rv, 20);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_frame", frame, 64'(0));
    chk("arst_cnt", 64'(bit_cnt), 64'(0));
    chk("arst_fcnt", 64'(frame_cnt), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_valid", 64'(frame_valid), 64'(0));
    chk("arst_err", 64'(frame_err), 64'(0));
    m_bits.delete();
    m_frame = '0;
    m_fcnt  = '0;
    cyc(2);
    rst = 1'b1;
    cyc(4);
    send_word(rv, 10);
    latch(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
